uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each received byte entry.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, at least 2.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 inData  in  DATA_WIDTH  received byte from the UART receiver.
REQ-006 inValid  in  1  one-cycle strobe; inData is valid this cycle (no backpressure upstream).
REQ-007 outData  out  DATA_WIDTH  head-of-queue byte; first-word-fall-through.
REQ-008 outValid  out  1  FIFO non-empty; outData is meaningful.
REQ-009 outReady  in  1  consumer accepts outData this cycle when outValid=1.
REQ-010 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 full  out  1  count == DEPTH.
REQ-012 overflow  out  1  sticky flag; a byte was dropped because the FIFO was full.
REQ-013 clearOverflow  in  1  one-cycle pulse; clears overflow.

Function
REQ-014 Storage SHALL be a DEPTH-entry array with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 Write: inValid=1 and (not full, or a pop in the same cycle) -> store inData at wrPtr, advance wrPtr by 1 at the next edge.
REQ-016 Pop: outValid=1 and outReady=1 -> advance rdPtr by 1 at the next edge; outReady while empty is ignored.
REQ-017 Latency: a byte written at edge N SHALL appear on outData with outValid=1 immediately after edge N (FIFO empty beforehand), i.e. one cycle after the inValid strobe.
REQ-018 outData SHALL always show the entry at rdPtr; its value while outValid=0 is don't-care.
REQ-019 count: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop or on neither.
REQ-020 Full plus inValid with a same-cycle pop: the write SHALL be accepted, count stays DEPTH, overflow is unchanged.
REQ-021 Full plus inValid with no pop: the byte is dropped, pointers and count are unchanged, and overflow SHALL be 1 from the next edge.
REQ-022 overflow SHALL stay set until clearOverflow=1 or rst; if clearOverflow and a new drop occur in the same cycle, overflow SHALL be 1 afterward (set wins).
REQ-023 Empty plus inValid plus outReady in the same cycle: no pop occurs (outValid was 0), the write is accepted, and count becomes 1.
REQ-024 The block SHALL have no other state; full and outValid SHALL be derived combinationally from count.

Reset
REQ-025 rst=1 at an edge SHALL set wrPtr=0, rdPtr=0, count=0, overflow=0; outValid=0 and full=0 follow.
REQ-026 rst SHALL take priority over inValid, outReady and clearOverflow in the same cycle; any in-flight data is discarded, including when rst is asserted mid-stream.
REQ-027 Array contents need not be reset.

Verification
REQ-028 After reset, strobe inValid with 0x41, outReady=0 -> next cycle outValid=1, outData=0x41, count=1.
REQ-029 Write 16 bytes 0x00..0x0F with no pops, then strobe 0xAA -> full=1, count=16, overflow=1; pop 16 times -> data 0x00..0x0F in order, 0xAA never seen, outValid=0 afterward.
REQ-030 With the FIFO full, strobe inValid=0x55 together with outReady=1 -> head pops, 0x55 is accepted as the last entry, count stays 16, overflow stays 0.
REQ-031 Drive 40 writes interleaved with pops, keeping count between 1 and 3 -> pointers wrap past DEPTH and output order matches input order exactly.
REQ-032 With overflow=1, pulse clearOverflow -> overflow=0 next cycle; repeat while full with inValid=1 and no pop in the same cycle -> overflow stays 1.
REQ-033 Load 5 bytes, assert rst for one cycle while inValid=1 and outReady=1 -> count=0, outValid=0, overflow=0 next cycle, and the strobed byte is not stored.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: first-word-fall-through output, occupancy
// count, and a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    inData,
  input  logic                     inValid,
  output logic [DATA_WIDTH-1:0]    outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clearOverflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  pop;
  logic                  write;
  logic                  drop;

  assign outValid = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign outData  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop   = outValid & outReady;
  assign write = inValid & (~full | pop);
  assign drop  = inValid & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new drop wins over a simultaneous clear.
      if (drop)               overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
    end
  end

  // Storage is not reset; a write is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && write) mem[wr_ptr] <= inData;
  end

endmodule
